// File: rtl/nybble_mem_pkg.sv
// Shared types and constants for the byte-wide memory arbiter.
// Word byte order is little-endian: low byte at A, high byte at A+1.
package nybble_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        ACK  = 2'd3
    } state_t;

    localparam logic GRANT_CPU = 1'b0;
    localparam logic GRANT_DBG = 1'b1;

    localparam int unsigned ADDR_WIDTH_DEF = 12;
    localparam int unsigned DATA_WIDTH     = 16;
    localparam int unsigned BYTE_WIDTH     = 8;

    // Byte selector within a word, equal to its offset from the word address
    localparam logic BYTE_SEL_LO = 1'b0;
    localparam logic BYTE_SEL_HI = 1'b1;

    // Access attributes latched at grant time
    typedef struct packed {
        logic                  we;
        logic                  word;
        logic [DATA_WIDTH-1:0] wdata;
    } req_attr_t;

    function automatic logic [BYTE_WIDTH-1:0] word_byte(input logic [DATA_WIDTH-1:0] w,
                                                        input logic                  sel);
        return (sel == BYTE_SEL_HI) ? w[15:8] : w[7:0];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] word_join(input logic [BYTE_WIDTH-1:0] lo,
                                                        input logic [BYTE_WIDTH-1:0] hi);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/mem_rr_pick.sv
// Two-way requester picker: round-robin on ties, or fixed debug priority
// when MEM_ARB_DBG_PRIORITY_EN is defined.
module mem_rr_pick
    import nybble_mem_pkg::*;
(
    input  logic req_cpu,
    input  logic req_dbg,
    input  logic last_grant,
    output logic valid,
    output logic pick
);

    assign valid = req_cpu | req_dbg;

`ifdef MEM_ARB_DBG_PRIORITY_EN
    logic unused_last_grant;
    assign unused_last_grant = last_grant;

    always_comb begin
        pick = GRANT_CPU;
        if (req_dbg) begin
            pick = GRANT_DBG;
        end
    end
`else
    // On a tie the port that was not served last wins
    always_comb begin
        pick = GRANT_CPU;
        if (req_cpu && req_dbg) begin
            pick = ~last_grant;
        end else if (req_dbg) begin
            pick = GRANT_DBG;
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one byte-wide synchronous-read memory between CPU and debug ports,
// splitting 16-bit accesses into two byte cycles. Option: MEM_ARB_DBG_PRIORITY_EN.
module mem_arbiter
    import nybble_mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter logic        RR_INIT    = GRANT_DBG
) (
    input  logic                  clock,
    input  logic                  reset_n,

    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic                  cpu_word,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [15:0]           cpu_wdata,
    output logic [15:0]           cpu_rdata,
    output logic                  cpu_ack,

    input  logic                  dbg_req,
    input  logic                  dbg_we,
    input  logic                  dbg_word,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    input  logic [15:0]           dbg_wdata,
    output logic [15:0]           dbg_rdata,
    output logic                  dbg_ack,

    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [7:0]            mem_wdata,
    input  logic [7:0]            mem_rdata,

    output logic                  busy,
    output logic                  grant
);

    state_t                state_q,      state_d;
    logic                  grant_q,      grant_d;
    logic                  last_grant_q, last_grant_d;
    logic [ADDR_WIDTH-1:0] addr_q,       addr_d;
    req_attr_t             attr_q,       attr_d;
    logic [7:0]            lo_byte_q,    lo_byte_d;
    logic                  cpu_ack_q,    cpu_ack_d;
    logic                  dbg_ack_q,    dbg_ack_d;
    logic [15:0]           cpu_rdata_q,  cpu_rdata_d;
    logic [15:0]           dbg_rdata_q,  dbg_rdata_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q,   mem_addr_d;
    logic                  mem_we_q,     mem_we_d;
    logic [7:0]            mem_wdata_q,  mem_wdata_d;
    logic                  busy_q,       busy_d;

    logic                  pick_valid_c;
    logic                  pick_c;
    logic [ADDR_WIDTH-1:0] sel_addr_c;
    req_attr_t             sel_attr_c;
    logic [15:0]           rd_word_c;

    mem_rr_pick u_pick (
        .req_cpu    (cpu_req),
        .req_dbg    (dbg_req),
        .last_grant (last_grant_q),
        .valid      (pick_valid_c),
        .pick       (pick_c)
    );

    // Request fields of the port the picker selected
    always_comb begin
        sel_addr_c       = cpu_addr;
        sel_attr_c.we    = cpu_we;
        sel_attr_c.word  = cpu_word;
        sel_attr_c.wdata = cpu_wdata;
        if (pick_c == GRANT_DBG) begin
            sel_addr_c       = dbg_addr;
            sel_attr_c.we    = dbg_we;
            sel_attr_c.word  = dbg_word;
            sel_attr_c.wdata = dbg_wdata;
        end
    end

    // Read result as seen in ACK: memory returns the last addressed byte now
    assign rd_word_c = attr_q.word ? word_join(lo_byte_q, mem_rdata)
                                   : {8'h00, mem_rdata};

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        attr_d       = attr_q;
        lo_byte_d    = lo_byte_q;
        cpu_ack_d    = 1'b0;
        dbg_ack_d    = 1'b0;
        cpu_rdata_d  = cpu_rdata_q;
        dbg_rdata_d  = dbg_rdata_q;
        mem_addr_d   = mem_addr_q;
        mem_we_d     = 1'b0;
        mem_wdata_d  = mem_wdata_q;
        busy_d       = busy_q;

        case (state_q)
            IDLE: begin
                if (pick_valid_c) begin
                    state_d      = LO;
                    grant_d      = pick_c;
                    last_grant_d = pick_c;
                    addr_d       = sel_addr_c;
                    attr_d       = sel_attr_c;
                    mem_addr_d   = sel_addr_c;
                    mem_we_d     = sel_attr_c.we;
                    mem_wdata_d  = word_byte(sel_attr_c.wdata, BYTE_SEL_LO);
                    busy_d       = 1'b1;
                end
            end
            LO: begin
                if (attr_q.word) begin
                    state_d     = HI;
                    mem_addr_d  = addr_q + ADDR_WIDTH'(1);
                    mem_we_d    = attr_q.we;
                    mem_wdata_d = word_byte(attr_q.wdata, BYTE_SEL_HI);
                end else begin
                    state_d   = ACK;
                    cpu_ack_d = (grant_q == GRANT_CPU);
                    dbg_ack_d = (grant_q == GRANT_DBG);
                end
            end
            HI: begin
                state_d   = ACK;
                lo_byte_d = mem_rdata;
                cpu_ack_d = (grant_q == GRANT_CPU);
                dbg_ack_d = (grant_q == GRANT_DBG);
            end
            ACK: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                if (!attr_q.we) begin
                    if (grant_q == GRANT_CPU) begin
                        cpu_rdata_d = rd_word_c;
                    end else begin
                        dbg_rdata_d = rd_word_c;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            grant_q      <= GRANT_CPU;
            last_grant_q <= RR_INIT;
            addr_q       <= '0;
            attr_q       <= '0;
            lo_byte_q    <= '0;
            cpu_ack_q    <= 1'b0;
            dbg_ack_q    <= 1'b0;
            cpu_rdata_q  <= '0;
            dbg_rdata_q  <= '0;
            mem_addr_q   <= '0;
            mem_we_q     <= 1'b0;
            mem_wdata_q  <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            attr_q       <= attr_d;
            lo_byte_q    <= lo_byte_d;
            cpu_ack_q    <= cpu_ack_d;
            dbg_ack_q    <= dbg_ack_d;
            cpu_rdata_q  <= cpu_rdata_d;
            dbg_rdata_q  <= dbg_rdata_d;
            mem_addr_q   <= mem_addr_d;
            mem_we_q     <= mem_we_d;
            mem_wdata_q  <= mem_wdata_d;
            busy_q       <= busy_d;
        end
    end

    // Read data must be visible in the ack cycle itself, so it bypasses the holding register
    assign cpu_rdata = (cpu_ack_q && !attr_q.we) ? rd_word_c : cpu_rdata_q;
    assign dbg_rdata = (dbg_ack_q && !attr_q.we) ? rd_word_c : dbg_rdata_q;
    assign cpu_ack   = cpu_ack_q;
    assign dbg_ack   = dbg_ack_q;
    assign mem_addr  = mem_addr_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;
    assign grant     = grant_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: drivers push expected results, a monitor
// checks arbitration, latency and read data on every ack.
module tb_mem_arbiter;

    localparam int unsigned AW = 12;
    localparam int unsigned MEM_DEPTH = 4096;

`ifdef MEM_ARB_DBG_PRIORITY_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    typedef struct {
        logic        we;
        logic        word;
        logic [15:0] data;
    } exp_t;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          cpu_req, cpu_we, cpu_word;
    logic [AW-1:0] cpu_addr;
    logic [15:0]   cpu_wdata, cpu_rdata;
    logic          cpu_ack;
    logic          dbg_req, dbg_we, dbg_word;
    logic [AW-1:0] dbg_addr;
    logic [15:0]   dbg_wdata, dbg_rdata;
    logic          dbg_ack;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [7:0]    mem_wdata, mem_rdata;
    logic          busy, grant;

    mem_arbiter dut (
        .clock     (clock),     .reset_n   (reset_n),
        .cpu_req   (cpu_req),   .cpu_we    (cpu_we),    .cpu_word  (cpu_word),
        .cpu_addr  (cpu_addr),  .cpu_wdata (cpu_wdata), .cpu_rdata (cpu_rdata),
        .cpu_ack   (cpu_ack),
        .dbg_req   (dbg_req),   .dbg_we    (dbg_we),    .dbg_word  (dbg_word),
        .dbg_addr  (dbg_addr),  .dbg_wdata (dbg_wdata), .dbg_rdata (dbg_rdata),
        .dbg_ack   (dbg_ack),
        .mem_addr  (mem_addr),  .mem_we    (mem_we),    .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata), .busy      (busy),      .grant     (grant)
    );

    always #5 clock = ~clock;

    // Memory macro stand-in
    logic [7:0] mem [0:MEM_DEPTH-1];
    logic       mem_clr;
    always @(posedge clock) begin
        if (mem_clr) begin
            for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= 8'h00;
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
        mem_rdata <= mem[mem_addr];
    end

    // Reference model state
    logic [7:0] ref_mem [0:MEM_DEPTH-1];
    exp_t       q_cpu[$];
    exp_t       q_dbg[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         cycle   = 0;
    bit         tie_phase = 1'b0;
    logic       grant_log[$];

    always @(posedge clock) cycle <= cycle + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic ack_of(input int p);
        return (p != 0) ? dbg_ack : cpu_ack;
    endfunction

    task automatic set_port(input int p, input logic req, input logic we, input logic word,
                            input logic [AW-1:0] addr, input logic [15:0] wdata);
        if (p == 0) begin
            cpu_req = req; cpu_we = we; cpu_word = word; cpu_addr = addr; cpu_wdata = wdata;
        end else begin
            dbg_req = req; dbg_we = we; dbg_word = word; dbg_addr = addr; dbg_wdata = wdata;
        end
    endtask

    task automatic push_exp(input int p, input exp_t e);
        if (p == 0) q_cpu.push_back(e);
        else        q_dbg.push_back(e);
    endtask

    // Expected effect of one access on the reference memory
    task automatic model_access(input int p, input logic we, input logic word,
                                input logic [AW-1:0] addr, input logic [15:0] wdata);
        exp_t          e;
        logic [AW-1:0] a1;
        a1     = addr + 12'd1;
        e.we   = we;
        e.word = word;
        e.data = 16'h0000;
        if (we) begin
            ref_mem[addr] = wdata[7:0];
            if (word) ref_mem[a1] = wdata[15:8];
        end else begin
            e.data = word ? {ref_mem[a1], ref_mem[addr]} : {8'h00, ref_mem[addr]};
        end
        push_exp(p, e);
    endtask

    // One request/ack handshake; request fields are scrambled once the access is underway
    task automatic drive_op(input int p, input logic we, input logic word,
                            input logic [AW-1:0] addr, input logic [15:0] wdata);
        bit done;
        int cyc;
        model_access(p, we, word, addr, wdata);
        set_port(p, 1'b1, we, word, addr, wdata);
        done = 1'b0;
        cyc  = 0;
        while (!done && cyc < 64) begin
            @(posedge clock); #1;
            cyc++;
            if (ack_of(p)) done = 1'b1;
            else if (busy && (grant == p[0]))
                set_port(p, 1'b1, 1'($urandom), 1'($urandom), AW'($urandom), 16'($urandom));
        end
        check($sformatf("ack_timeout_p%0d", p), 32'(done), 32'd1);
        @(posedge clock); #1;
        set_port(p, 1'b0, 1'b0, 1'b0, '0, '0);
        @(posedge clock); #1;
    endtask

    // Hold a byte-read request high across several back-to-back accesses
    task automatic tie_port(input int p, input logic [AW-1:0] addr, input int n);
        int got;
        int cyc;
        for (int i = 0; i < n; i++) model_access(p, 1'b0, 1'b0, addr, 16'h0000);
        set_port(p, 1'b1, 1'b0, 1'b0, addr, 16'h0000);
        got = 0;
        cyc = 0;
        while (got < n && cyc < 200) begin
            @(posedge clock); #1;
            cyc++;
            if (ack_of(p)) got++;
        end
        check($sformatf("tie_acks_p%0d", p), 32'(got), 32'(n));
        @(posedge clock); #1;
        set_port(p, 1'b0, 1'b0, 1'b0, '0, '0);
        @(posedge clock); #1;
    endtask

    task automatic rand_port(input int p, input int n);
        logic [AW-1:0] a;
        for (int i = 0; i < n; i++) begin
            a = (p == 0) ? AW'($urandom_range(0, 2046)) : AW'($urandom_range(2048, 4094));
            repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
            drive_op(p, 1'($urandom), 1'($urandom), a, 16'($urandom));
        end
    endtask

    // Monitor: arbitration model, latency and read data checks
    logic model_last;
    logic model_rd_cpu_unused;
    logic [15:0] model_rdata [0:1];
    logic prev_busy, prev_cpu_req, prev_dbg_req;
    int   start_cyc;
    exp_t mon_e;

    always @(negedge clock) begin
        if (!reset_n) begin
            model_last     = 1'b1;
            model_rdata[0] = 16'h0000;
            model_rdata[1] = 16'h0000;
            prev_busy      = 1'b0;
            prev_cpu_req   = 1'b0;
            prev_dbg_req   = 1'b0;
        end else begin
            if (busy && !prev_busy) begin
                logic exp_own;
                if (prev_cpu_req && prev_dbg_req) exp_own = PRIO ? 1'b1 : ~model_last;
                else                              exp_own = prev_dbg_req;
                check("arb_grant", 32'(grant), 32'(exp_own));
                model_last = exp_own;
                start_cyc  = cycle;
                if (tie_phase) grant_log.push_back(grant);
            end
            if (cpu_ack && dbg_ack) begin
                check("dual_ack", 32'({cpu_ack, dbg_ack}), 32'b01);
            end else if (cpu_ack || dbg_ack) begin
                int p;
                bit have;
                logic [15:0] exp_rd;
                p    = dbg_ack ? 1 : 0;
                have = (p == 0) ? (q_cpu.size() != 0) : (q_dbg.size() != 0);
                check("ack_owner", 32'(grant), 32'(p));
                check("ack_expected", 32'(have), 32'd1);
                if (have) begin
                    mon_e  = (p == 0) ? q_cpu.pop_front() : q_dbg.pop_front();
                    exp_rd = mon_e.we ? model_rdata[p] : mon_e.data;
                    check("ack_latency", 32'(cycle - start_cyc), mon_e.word ? 32'd2 : 32'd1);
                    check($sformatf("rdata_p%0d", p), 32'((p == 0) ? cpu_rdata : dbg_rdata), 32'(exp_rd));
                    model_rdata[p] = exp_rd;
                    check("nonowner_rdata_hold", 32'((p == 0) ? dbg_rdata : cpu_rdata),
                          32'(model_rdata[1-p]));
                end
            end
            prev_busy    = busy;
            prev_cpu_req = cpu_req;
            prev_dbg_req = dbg_req;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        int cyc;
        int bad;
        reset_n = 1'b0;
        mem_clr = 1'b1;
        set_port(0, 1'b0, 1'b0, 1'b0, '0, '0);
        set_port(1, 1'b0, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < MEM_DEPTH; i++) ref_mem[i] = 8'h00;
        repeat (3) @(posedge clock);
        #1;
        check("rst_cpu_ack",   32'(cpu_ack),   32'd0);
        check("rst_dbg_ack",   32'(dbg_ack),   32'd0);
        check("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
        check("rst_dbg_rdata", 32'(dbg_rdata), 32'd0);
        check("rst_mem_we",    32'(mem_we),    32'd0);
        check("rst_mem_addr",  32'(mem_addr),  32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_grant",     32'(grant),     32'd0);
        mem_clr = 1'b0;
        reset_n = 1'b1;
        @(posedge clock); #1;

        // Directed accesses, including address wrap
        drive_op(0, 1'b1, 1'b1, 12'h100, 16'hBEEF);
        drive_op(0, 1'b0, 1'b1, 12'h100, 16'h0000);
        drive_op(1, 1'b0, 1'b0, 12'h101, 16'h0000);
        drive_op(0, 1'b1, 1'b1, 12'hFFF, 16'h1234);
        drive_op(1, 1'b0, 1'b0, 12'hFFF, 16'h0000);
        drive_op(1, 1'b0, 1'b0, 12'h000, 16'h0000);
        drive_op(0, 1'b0, 1'b1, 12'hFFF, 16'h0000);
        drive_op(1, 1'b1, 1'b0, 12'h123, 16'h5A77);
        drive_op(0, 1'b0, 1'b1, 12'h122, 16'h0000);

        // Concurrent random traffic on disjoint halves of memory
        fork
            rand_port(0, 40);
            rand_port(1, 40);
        join

        // Reset during the high byte of a word write
        set_port(0, 1'b1, 1'b1, 1'b1, 12'h200, 16'hAAAA);
        found = 1'b0;
        cyc   = 0;
        while (!found && cyc < 64) begin
            @(posedge clock); #1;
            cyc++;
            if (busy && grant == 1'b0) found = 1'b1;
        end
        check("rstop_granted", 32'(found),     32'd1);
        check("rstop_lo_addr", 32'(mem_addr),  32'h200);
        check("rstop_lo_we",   32'(mem_we),    32'd1);
        check("rstop_lo_data", 32'(mem_wdata), 32'hAA);
        @(posedge clock); #1;
        check("rstop_hi_addr", 32'(mem_addr),  32'h201);
        check("rstop_hi_we",   32'(mem_we),    32'd1);
        reset_n = 1'b0;
        #1;
        check("rstop_busy",    32'(busy),    32'd0);
        check("rstop_cpu_ack", 32'(cpu_ack), 32'd0);
        check("rstop_dbg_ack", 32'(dbg_ack), 32'd0);
        check("rstop_mem_we",  32'(mem_we),  32'd0);
        set_port(0, 1'b0, 1'b0, 1'b0, '0, '0);
        ref_mem[12'h200] = 8'hAA;
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(posedge clock); #1;
        check("post_rst_busy",  32'(busy),      32'd0);
        check("post_rst_grant", 32'(grant),     32'd0);
        check("post_rst_rdata", 32'(cpu_rdata), 32'd0);

        // Both requests held: alternating grants (or debug first with fixed priority)
        tie_phase = 1'b1;
        fork
            tie_port(0, 12'h100, 3);
            tie_port(1, 12'h101, 3);
        join
        tie_phase = 1'b0;
        check("tie_grant_count", 32'(grant_log.size() >= 4), 32'd1);
        if (grant_log.size() >= 4) begin
            check("tie_grant0", 32'(grant_log[0]), PRIO ? 32'd1 : 32'd0);
            check("tie_grant1", 32'(grant_log[1]), 32'd1);
            check("tie_grant2", 32'(grant_log[2]), PRIO ? 32'd1 : 32'd0);
            check("tie_grant3", 32'(grant_log[3]), PRIO ? 32'd0 : 32'd1);
        end

        // Half-written word is visible after reset
        drive_op(0, 1'b0, 1'b0, 12'h200, 16'h0000);
        drive_op(1, 1'b0, 1'b1, 12'h200, 16'h0000);

        check("queue_cpu_empty", 32'(q_cpu.size()), 32'd0);
        check("queue_dbg_empty", 32'(q_dbg.size()), 32'd0);
        bad = 0;
        for (int i = 0; i < MEM_DEPTH; i++) if (mem[i] !== ref_mem[i]) bad++;
        check("mem_image_mismatches", 32'(bad), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
